// File: rtl/matmul_pkg.sv
// Shared types and defaults for the matrix-multiply sequencer slice.
package matmul_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   localparam int unsigned DEF_N      = 4;
   localparam int unsigned DEF_AW     = 10;
   localparam int unsigned DEF_CW     = 9;
   localparam int unsigned DEF_MCW    = 10;
   localparam int unsigned PIPE_DEPTH = 2;

   // Index counter width; a 1x1 matrix still needs a 1-bit counter.
   function automatic int unsigned idx_w(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/matmul_sequencer_if.sv
// Control bus between the sequencer and the RAM/MAC datapath plus its requester.
interface matmul_sequencer_if
   import matmul_pkg::*;
#(
   parameter int unsigned AW  = DEF_AW,
   parameter int unsigned CW  = DEF_CW,
   parameter int unsigned MCW = DEF_MCW
);
   logic           start;
   logic [AW-1:0]  addr_a;
   logic [AW-1:0]  addr_b;
   logic           mac_clear;
   logic           mac_en;
   logic           wren_c;
   logic [CW-1:0]  addr_c;
   logic           busy;
   logic           done;
   logic [MCW-1:0] mult_count;

   modport master (
      input  start,
      output addr_a, addr_b, mac_clear, mac_en, wren_c, addr_c, busy, done, mult_count
   );

   modport slave (
      output start,
      input  addr_a, addr_b, mac_clear, mac_en, wren_c, addr_c, busy, done, mult_count
   );
endinterface

// File: rtl/matmul_index_counter.sv
// Nested i/j/k walker (k fastest) with registered first/last/final-index flags.
module matmul_index_counter #(
   parameter int unsigned N  = 4,
   parameter int unsigned IW = 2
) (
   input  logic          clock,
   input  logic          reset_n,
   input  logic          clear,
   input  logic          en,
   output logic [IW-1:0] i,
   output logic [IW-1:0] j,
   output logic [IW-1:0] k,
   output logic          first,
   output logic          last_k,
   output logic          wrap_all
);
   localparam logic [IW-1:0] MAX = IW'(N - 1);

   logic [IW-1:0] i_d, j_d, k_d;

   always_comb begin
      i_d = i;
      j_d = j;
      k_d = k;
      if (clear) begin
         i_d = '0;
         j_d = '0;
         k_d = '0;
      end else if (en) begin
         if (k == MAX) begin
            k_d = '0;
            if (j == MAX) begin
               j_d = '0;
               i_d = (i == MAX) ? '0 : i + IW'(1);
            end else begin
               j_d = j + IW'(1);
            end
         end else begin
            k_d = k + IW'(1);
         end
      end
   end

   // Flags are derived from the next indices so they line up with the registered counters.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         i        <= '0;
         j        <= '0;
         k        <= '0;
         first    <= 1'b1;
         last_k   <= (MAX == '0);
         wrap_all <= (MAX == '0);
      end else begin
         i        <= i_d;
         j        <= j_d;
         k        <= k_d;
         first    <= (k_d == '0);
         last_k   <= (k_d == MAX);
         wrap_all <= (i_d == MAX) && (j_d == MAX) && (k_d == MAX);
      end
   end
endmodule

// File: rtl/matmul_sequencer.sv
// Walks (i,j,k) for an NxN multiply, drives A/B reads and MAC control, writes C.
module matmul_sequencer
   import matmul_pkg::*;
#(
   parameter int unsigned N   = DEF_N,
   parameter int unsigned AW  = DEF_AW,
   parameter int unsigned CW  = DEF_CW,
   parameter int unsigned MCW = DEF_MCW
) (
   input  logic               clock,
   input  logic               reset_n,
   matmul_sequencer_if.master bus
);
   localparam int unsigned IW = idx_w(N);
   localparam int unsigned PD = PIPE_DEPTH;

   if (longint'(N) * longint'(N) > (longint'(1) << CW)) begin : g_size_check
      $error("matmul_sequencer: N*N does not fit in the C address space");
   end

   state_e state_q, state_d;
   logic   accept_c, issue_c, idle_c;

   logic [IW-1:0] i, j, k;
   logic          first, last_k, wrap_all;

   logic [AW-1:0]  addr_a_q, addr_b_q;
   logic [CW-1:0]  addr_c_q;
   logic           wren_c_q, busy_q, done_q;
   logic [MCW-1:0] mult_count_q;

   logic [PD-1:0]  pipe_valid, pipe_first, pipe_last;
   logic [CW-1:0]  pipe_addr_c [PD];

   matmul_index_counter #(.N(N), .IW(IW)) u_index (
      .clock    (clock),
      .reset_n  (reset_n),
      .clear    (state_q == ST_IDLE),
      .en       (issue_c),
      .i        (i),
      .j        (j),
      .k        (k),
      .first    (first),
      .last_k   (last_k),
      .wrap_all (wrap_all)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // DRAIN ends once the issue stage is empty; the remaining stages retire on their own.
   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      issue_c  = 1'b0;
      idle_c   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            idle_c = 1'b1;
            if (bus.start) begin
               accept_c = 1'b1;
               state_d  = ST_RUN;
            end
         end
         ST_RUN: begin
            issue_c = 1'b1;
            if (wrap_all) state_d = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!pipe_valid[0]) state_d = ST_DONE;
         end
         ST_DONE: begin
            idle_c  = 1'b1;
            state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         addr_a_q     <= '0;
         addr_b_q     <= '0;
         addr_c_q     <= '0;
         wren_c_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         mult_count_q <= '0;
         pipe_valid   <= '0;
         pipe_first   <= '0;
         pipe_last    <= '0;
         for (int s = 0; s < int'(PD); s++) pipe_addr_c[s] <= '0;
      end else begin
         if (issue_c) begin
            addr_a_q <= AW'(i) * AW'(N) + AW'(k);
            addr_b_q <= AW'(k) * AW'(N) + AW'(j);
         end else if (idle_c) begin
            addr_a_q <= '0;
            addr_b_q <= '0;
         end

         pipe_valid <= {pipe_valid[PD-2:0], issue_c};
         pipe_first <= {pipe_first[PD-2:0], issue_c & first};
         pipe_last  <= {pipe_last[PD-2:0],  issue_c & last_k};
         if (issue_c) pipe_addr_c[0] <= CW'(i) * CW'(N) + CW'(j);
         for (int s = 1; s < int'(PD); s++) pipe_addr_c[s] <= pipe_addr_c[s-1];

         wren_c_q <= pipe_last[PD-1];
         if (pipe_last[PD-1])  addr_c_q <= pipe_addr_c[PD-1];
         else if (idle_c)      addr_c_q <= '0;

         busy_q <= (state_q == ST_RUN) || (state_q == ST_DRAIN);
         done_q <= (state_q == ST_DONE);

         if (accept_c)                           mult_count_q <= '0;
         else if (issue_c && (mult_count_q != '1)) mult_count_q <= mult_count_q + MCW'(1);
      end
   end

   assign bus.addr_a     = addr_a_q;
   assign bus.addr_b     = addr_b_q;
   assign bus.mac_en     = pipe_valid[PD-1];
   assign bus.mac_clear  = pipe_first[PD-1];
   assign bus.wren_c     = wren_c_q;
   assign bus.addr_c     = addr_c_q;
   assign bus.busy       = busy_q;
   assign bus.done       = done_q;
   assign bus.mult_count = mult_count_q;
endmodule
